// File: rtl/id_hazard_ctrl_if.sv
// Decoder/EX-side bundle for the ID hazard controller: slave is the controller, master is the pipeline around it.
interface id_hazard_ctrl_if #(
   parameter int REG_AW = 5
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_syscall;
   logic              id_break;
   logic              ex_branch_taken;
   logic              mem_stall;
   logic              trap_ack;
   logic              if_stall;
   logic              id_stall;
   logic              id_flush;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic              trap_req;
   logic [1:0]        trap_cause;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_mem_read, id_syscall, id_break,
             ex_branch_taken, mem_stall, trap_ack,
      input  if_stall, id_stall, id_flush, fwd_a_sel, fwd_b_sel, trap_req, trap_cause
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_mem_read, id_syscall, id_break,
             ex_branch_taken, mem_stall, trap_ack,
      output if_stall, id_stall, id_flush, fwd_a_sel, fwd_b_sel, trap_req, trap_cause
   );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/trap controller; stall, flush and forward selects are combinational, mem_stall freezes everything.
// HAZARD_FWD_EN enables EX/MEM/WB forwarding; without it any in-flight dependency stalls until the writer retires.
module id_hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   id_hazard_ctrl_if.slave bus
);
   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   typedef struct packed {
      logic              vld;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
   } shadow_t;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_TRAP} state_t;

   shadow_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    cause_q, cause_d;

   logic          hazard, issue, trap_op;
   logic          if_stall_c, id_stall_c, id_flush_c, trap_req_c;
   logic [1:0]    trap_cause_c;

   function automatic logic hit(input shadow_t s, input logic [REG_AW-1:0] rs,
                                input logic use_rs, input logic load_only);
      return use_rs && s.vld && s.reg_write && (s.rd == rs) && (rs != '0) &&
             (!load_only || s.mem_read);
   endfunction

`ifdef HAZARD_FWD_EN
   function automatic logic [1:0] fwd_src(input shadow_t ex, input shadow_t mem, input shadow_t wb,
                                          input logic [REG_AW-1:0] rs, input logic use_rs);
      if (hit(ex, rs, use_rs, 1'b0) && !ex.mem_read) return 2'b01;
      if (hit(mem, rs, use_rs, 1'b0))                return 2'b10;
      if (hit(wb, rs, use_rs, 1'b0))                 return 2'b11;
      return 2'b00;
   endfunction

   // Only a load still in EX cannot be forwarded; everything else is bypassed.
   assign hazard = bus.id_valid &&
                   (hit(ex_q, bus.id_rs1, bus.id_use_rs1, 1'b1) ||
                    hit(ex_q, bus.id_rs2, bus.id_use_rs2, 1'b1));

   assign bus.fwd_a_sel = rst_n ? fwd_src(ex_q, mem_q, wb_q, bus.id_rs1, bus.id_use_rs1) : 2'b00;
   assign bus.fwd_b_sel = rst_n ? fwd_src(ex_q, mem_q, wb_q, bus.id_rs2, bus.id_use_rs2) : 2'b00;
`else
   assign hazard = bus.id_valid &&
                   (hit(ex_q,  bus.id_rs1, bus.id_use_rs1, 1'b0) ||
                    hit(ex_q,  bus.id_rs2, bus.id_use_rs2, 1'b0) ||
                    hit(mem_q, bus.id_rs1, bus.id_use_rs1, 1'b0) ||
                    hit(mem_q, bus.id_rs2, bus.id_use_rs2, 1'b0) ||
                    hit(wb_q,  bus.id_rs1, bus.id_use_rs1, 1'b0) ||
                    hit(wb_q,  bus.id_rs2, bus.id_use_rs2, 1'b0));

   assign bus.fwd_a_sel = 2'b00;
   assign bus.fwd_b_sel = 2'b00;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cause_d      = cause_q;
      ex_d         = ex_q;
      mem_d        = mem_q;
      wb_d         = wb_q;
      issue        = 1'b0;
      if_stall_c   = 1'b0;
      id_stall_c   = 1'b0;
      id_flush_c   = bus.ex_branch_taken;
      trap_req_c   = 1'b0;
      trap_cause_c = 2'b00;
      trap_op      = bus.id_syscall || bus.id_break;

      unique case (state_q)
         S_RUN: begin
            // A taken branch kills the ID instruction, so it must not stall it.
            id_stall_c = hazard && !bus.ex_branch_taken;
            issue      = bus.id_valid && !id_stall_c && !bus.mem_stall && !bus.ex_branch_taken;
            if_stall_c = id_stall_c || (issue && trap_op);
            if (issue && trap_op) begin
               state_d = S_DRAIN;
               cnt_d   = CW'(DRAIN_CYCLES);
               cause_d = bus.id_break ? 2'b10 : 2'b01;
            end
         end
         S_DRAIN: begin
            id_stall_c = 1'b1;
            if_stall_c = 1'b1;
            if (!bus.mem_stall) begin
               if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
               // Nothing issues while draining, so next-cycle shadows are empty once EX and MEM are.
               if (cnt_d == '0 && !ex_q.vld && !mem_q.vld) state_d = S_TRAP;
            end
         end
         S_TRAP: begin
            id_stall_c   = 1'b1;
            if_stall_c   = 1'b1;
            trap_req_c   = 1'b1;
            trap_cause_c = cause_q;
            if (bus.trap_ack && !bus.mem_stall) begin
               id_flush_c = 1'b1;
               cause_d    = 2'b00;
               state_d    = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase

      if (bus.mem_stall) begin
         if_stall_c = 1'b1;
         id_stall_c = 1'b1;
      end else begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = '0;
         if (issue) begin
            ex_d.vld       = 1'b1;
            ex_d.rd        = bus.id_rd;
            ex_d.reg_write = bus.id_reg_write;
            ex_d.mem_read  = bus.id_mem_read;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
         cause_q <= 2'b00;
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
      end
   end

   assign bus.if_stall   = rst_n && if_stall_c;
   assign bus.id_stall   = rst_n && id_stall_c;
   assign bus.id_flush   = rst_n && id_flush_c;
   assign bus.trap_req   = rst_n && trap_req_c;
   assign bus.trap_cause = rst_n ? trap_cause_c : 2'b00;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl; expectations follow the HAZARD_FWD_EN setting of the build.
module tb_id_hazard_ctrl;
   logic clk;
   logic rst_n;
   int   n_run;
   int   n_fail;

   id_hazard_ctrl_if #(.REG_AW(5)) bus ();

   id_hazard_ctrl #(.REG_AW(5), .DRAIN_CYCLES(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_valid        = 1'b0;
      bus.id_rs1          = '0;
      bus.id_rs2          = '0;
      bus.id_use_rs1      = 1'b0;
      bus.id_use_rs2      = 1'b0;
      bus.id_rd           = '0;
      bus.id_reg_write    = 1'b0;
      bus.id_mem_read     = 1'b0;
      bus.id_syscall      = 1'b0;
      bus.id_break        = 1'b0;
      bus.ex_branch_taken = 1'b0;
      bus.mem_stall       = 1'b0;
      bus.trap_ack        = 1'b0;
   endtask

   task automatic drv(input int rs1, input int rs2, input logic u1, input logic u2, input int rd,
                      input logic rw, input logic mr, input logic sys, input logic brk);
      logic [31:0] a, b, d;
      a = rs1; b = rs2; d = rd;
      idle();
      bus.id_valid     = 1'b1;
      bus.id_rs1       = a[4:0];
      bus.id_rs2       = b[4:0];
      bus.id_use_rs1   = u1;
      bus.id_use_rs2   = u2;
      bus.id_rd        = d[4:0];
      bus.id_reg_write = rw;
      bus.id_mem_read  = mr;
      bus.id_syscall   = sys;
      bus.id_break     = brk;
   endtask

   // Holds the current ID instruction until it issues; reports stall count and selects at issue.
   task automatic wait_issue(output int stalls, output logic ifs0, output logic [1:0] sa,
                             output logic [1:0] sb, output logic done);
      stalls = 0; done = 1'b0; sa = 2'b00; sb = 2'b00; ifs0 = 1'b0;
      for (int c = 0; c < 8 && !done; c++) begin
         @(negedge clk);
         if (c == 0) ifs0 = bus.if_stall;
         if (bus.id_stall) stalls++;
         else begin
            done = 1'b1;
            sa   = bus.fwd_a_sel;
            sb   = bus.fwd_b_sel;
         end
         tick();
      end
      idle();
   endtask

   task automatic dist_test(input int k);
      int stalls; logic ifs0, done; logic [1:0] sa, sb;
      int exp_st, exp_a;
`ifdef HAZARD_FWD_EN
      exp_st = 0; exp_a = k;
`else
      exp_st = 4 - k; exp_a = 0;
`endif
      idle(); repeat (4) tick();
      drv(0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
      for (int j = 1; j < k; j++) begin
         drv(0, 0, 0, 0, 9, 1, 0, 0, 0); tick();
      end
      drv(5, 0, 1, 1, 6, 1, 0, 0, 0);
      wait_issue(stalls, ifs0, sa, sb, done);
      check($sformatf("dist%0d_issued", k), 32'(done), 32'd1);
      check($sformatf("dist%0d_stalls", k), 32'(stalls), 32'(exp_st));
      check($sformatf("dist%0d_if_stall", k), 32'(ifs0), 32'(exp_st != 0));
      check($sformatf("dist%0d_fwd_a", k), 32'(sa), 32'(exp_a));
      check($sformatf("dist%0d_fwd_b_x0", k), 32'(sb), 32'd0);
   endtask

   task automatic trap_test(input string nm, input logic sys, input logic brk, input int ms_cycles,
                            input int exp_drain, input logic [1:0] exp_cause);
      int drain; logic seen;
      idle(); repeat (4) tick();
      drv(0, 0, 0, 0, 0, 0, 0, sys, brk);
      @(negedge clk);
      check({nm, "_issue_if_stall"}, 32'(bus.if_stall), 32'd1);
      check({nm, "_issue_id_stall"}, 32'(bus.id_stall), 32'd0);
      tick(); idle();
      drain = 0; seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         bus.mem_stall = (c >= 1 && c < 1 + ms_cycles);
         @(negedge clk);
         if (bus.trap_req) seen = 1'b1;
         else drain++;
         tick();
      end
      bus.mem_stall = 1'b0;
      check({nm, "_trap_seen"}, 32'(seen), 32'd1);
      check({nm, "_drain_cycles"}, 32'(drain), 32'(exp_drain));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check({nm, "_cause_held"}, 32'({bus.trap_req, bus.if_stall, bus.id_stall, bus.trap_cause}),
               32'({3'b111, exp_cause}));
         tick();
      end
      bus.trap_ack = 1'b1;
      @(negedge clk);
      check({nm, "_ack_flush"}, 32'(bus.id_flush), 32'd1);
      tick(); idle();
      @(negedge clk);
      check({nm, "_after_ack"}, 32'({bus.trap_req, bus.trap_cause, bus.id_flush, bus.id_stall}), 32'd0);
      tick();
   endtask

   initial begin
      int stalls; logic ifs0, done, seen; logic [1:0] sa, sb;
      int exp_lu_st; logic [1:0] exp_lu_sel;
      n_run = 0; n_fail = 0;
      rst_n = 1'b0;
      idle();
      bus.id_valid = 1'b1; bus.mem_stall = 1'b1; bus.ex_branch_taken = 1'b1;
      bus.id_syscall = 1'b1; bus.trap_ack = 1'b1; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
      #3;
      check("rst_if_stall", 32'(bus.if_stall), 32'd0);
      check("rst_id_stall", 32'(bus.id_stall), 32'd0);
      check("rst_id_flush", 32'(bus.id_flush), 32'd0);
      check("rst_trap", 32'({bus.trap_req, bus.trap_cause}), 32'd0);
      check("rst_fwd", 32'({bus.fwd_a_sel, bus.fwd_b_sel}), 32'd0);
      idle();
      tick();
      rst_n = 1'b1;

      bus.trap_ack = 1'b1;
      @(negedge clk);
      check("ack_in_run_flush", 32'(bus.id_flush), 32'd0);
      check("ack_in_run_trap", 32'(bus.trap_req), 32'd0);
      tick();

      drv(0, 0, 0, 0, 5, 1, 0, 0, 0);
      @(negedge clk);
      check("first_issue_stall", 32'({bus.id_stall, bus.if_stall}), 32'd0);
      tick(); idle();

      bus.id_valid = 1'b1; bus.mem_stall = 1'b1;
      @(negedge clk);
      check("mem_stall_freeze", 32'({bus.id_stall, bus.if_stall}), 32'd3);
      tick(); idle();

      dist_test(1);
      dist_test(2);
      dist_test(3);

      idle(); repeat (4) tick();
      drv(0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
      drv(0, 0, 1, 1, 6, 1, 0, 0, 0);
      @(negedge clk);
      check("rd_x0_no_stall", 32'(bus.id_stall), 32'd0);
      check("rd_x0_fwd", 32'({bus.fwd_a_sel, bus.fwd_b_sel}), 32'd0);
      tick(); idle();

`ifdef HAZARD_FWD_EN
      exp_lu_st = 1; exp_lu_sel = 2'b10;
`else
      exp_lu_st = 3; exp_lu_sel = 2'b00;
`endif
      idle(); repeat (4) tick();
      drv(0, 0, 0, 0, 7, 1, 1, 0, 0); tick();
      drv(7, 7, 1, 1, 8, 1, 0, 0, 0);
      wait_issue(stalls, ifs0, sa, sb, done);
      check("lu_issued", 32'(done), 32'd1);
      check("lu_stalls", 32'(stalls), 32'(exp_lu_st));
      check("lu_if_stall", 32'(ifs0), 32'd1);
      check("lu_fwd_a", 32'(sa), 32'(exp_lu_sel));
      check("lu_fwd_b", 32'(sb), 32'(exp_lu_sel));

      idle(); repeat (4) tick();
      drv(0, 0, 0, 0, 7, 1, 1, 0, 0); tick();
      drv(7, 7, 1, 1, 8, 1, 0, 0, 0);
      bus.ex_branch_taken = 1'b1;
      @(negedge clk);
      check("lu_br_flush", 32'(bus.id_flush), 32'd1);
      check("lu_br_no_stall", 32'({bus.id_stall, bus.if_stall}), 32'd0);
      tick(); idle();

      trap_test("ecall", 1'b1, 1'b0, 0, 3, 2'b01);
      trap_test("ecall_ms", 1'b1, 1'b0, 2, 5, 2'b01);
      trap_test("ebreak", 1'b0, 1'b1, 0, 3, 2'b10);
      trap_test("both", 1'b1, 1'b1, 0, 3, 2'b10);

      idle(); repeat (4) tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      bus.ex_branch_taken = 1'b1;
      @(negedge clk);
      check("brk_br_flush", 32'(bus.id_flush), 32'd1);
      check("brk_br_if_stall", 32'(bus.if_stall), 32'd0);
      tick(); idle();
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.trap_req) seen = 1'b1;
         tick();
      end
      check("brk_br_no_trap", 32'(seen), 32'd0);

      idle(); repeat (4) tick();
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); idle(); tick();
      rst_n = 1'b0;
      #1;
      check("rst_drain_out", 32'({bus.if_stall, bus.id_stall, bus.trap_req}), 32'd0);
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.trap_req) seen = 1'b1;
         tick();
      end
      check("rst_drain_no_trap", 32'(seen), 32'd0);
      drv(0, 0, 0, 0, 3, 1, 0, 0, 0);
      @(negedge clk);
      check("rst_drain_run", 32'(bus.id_stall), 32'd0);
      tick(); idle();

      repeat (4) tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1); tick(); idle();
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (bus.trap_req) seen = 1'b1;
         else tick();
      end
      check("rst_trap_reached", 32'(seen), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_trap_out", 32'({bus.trap_req, bus.trap_cause, bus.id_stall}), 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_trap_run", 32'({bus.trap_req, bus.if_stall}), 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
